// File: rtl/pwm_multichannel_core.sv
// NUM_CH-channel PWM: shared prescaler and up/down period counter, per-channel compare pair.
// Define PWM_SHADOW_UPDATE_EN for period-boundary (shadowed) PERIOD/COMPARE/FUNCTION updates.
module pwm_multichannel_core #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [5:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  logic               en_q, up_q;
  logic [PRESC_W-1:0] presc_q, pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]  pen_q, pwm_q, pwm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]   per_q, per_v, per_w;
  logic [CNT_W-1:0]   c1_q [NUM_CH];
  logic [CNT_W-1:0]   c2_q [NUM_CH];
  logic [1:0]         fn_q [NUM_CH];
  logic [CNT_W-1:0]   c1_v [NUM_CH];
  logic [CNT_W-1:0]   c2_v [NUM_CH];
  logic [1:0]         fn_v [NUM_CH];
  logic [CNT_W-1:0]   c1_w [NUM_CH];
  logic [CNT_W-1:0]   c2_w [NUM_CH];
  logic [1:0]         fn_w [NUM_CH];
  logic               we_ctrl, clr, tick, wrap, upd, load;

  assign we_ctrl = cfg_we && (cfg_addr == 6'h00);
  assign clr     = we_ctrl && cfg_wdata[2];
  assign tick    = en_q && (pcnt_q >= presc_q);
  assign wrap    = up_q ? (cnt_q >= per_q) : (cnt_q == '0);
  assign upd     = tick && wrap && !clr;

`ifdef PWM_SHADOW_UPDATE_EN
  logic [CNT_W-1:0] per_s_q;
  logic [CNT_W-1:0] c1_s_q [NUM_CH];
  logic [CNT_W-1:0] c2_s_q [NUM_CH];
  logic [1:0]       fn_s_q [NUM_CH];

  assign per_v = per_s_q;
  assign c1_v  = c1_s_q;
  assign c2_v  = c2_s_q;
  assign fn_v  = fn_s_q;
  // while stopped there is no period to protect, so shadows pass straight through
  assign load  = upd || !en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_s_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c1_s_q[ch] <= '0;
        c2_s_q[ch] <= '0;
        fn_s_q[ch] <= '0;
      end
    end else begin
      per_s_q <= per_w;
      c1_s_q  <= c1_w;
      c2_s_q  <= c2_w;
      fn_s_q  <= fn_w;
    end
  end
`else
  assign per_v = per_q;
  assign c1_v  = c1_q;
  assign c2_v  = c2_q;
  assign fn_v  = fn_q;
  assign load  = 1'b1;
`endif

  always_comb begin
    per_w = per_v;
    c1_w  = c1_v;
    c2_w  = c2_v;
    fn_w  = fn_v;
    if (cfg_we && cfg_addr == 6'h01) per_w = cfg_wdata;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cfg_we && cfg_addr == 6'(16 + 2*ch)) c1_w[ch] = cfg_wdata;
      if (cfg_we && cfg_addr == 6'(17 + 2*ch)) c2_w[ch] = cfg_wdata;
      if (cfg_we && cfg_addr == 6'(32 + ch))   fn_w[ch] = cfg_wdata[1:0];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    if (clr) begin
      cnt_d  = '0;
      pcnt_d = '0;
    end else if (en_q) begin
      if (tick) begin
        pcnt_d = '0;
        if (wrap)      cnt_d = up_q ? '0 : per_q;
        else if (up_q) cnt_d = cnt_q + CNT_W'(1);
        else           cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pcnt_d = pcnt_q + PRESC_W'(1);
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      unique case (fn_q[ch])
        2'b00:   pwm_d[ch] = (c1_q[ch] != '0) && (cnt_q <= c1_q[ch]);
        2'b01:   pwm_d[ch] = (cnt_q >= c1_q[ch]);
        2'b10:   pwm_d[ch] = (cnt_q >= c1_q[ch]) && (cnt_q < c2_q[ch]);
        default: pwm_d[ch] = 1'b0;
      endcase
      pwm_d[ch] = pwm_d[ch] && pen_q[ch];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = '0;
      if (cfg_addr == 6'h00) rdata_d = CNT_W'({up_q, en_q});
      if (cfg_addr == 6'h01) rdata_d = per_v;
      if (cfg_addr == 6'h02) rdata_d = CNT_W'(presc_q);
      if (cfg_addr == 6'h03) rdata_d = CNT_W'(pen_q);
      if (cfg_addr == 6'h04) rdata_d = cnt_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cfg_addr == 6'(16 + 2*ch)) rdata_d = c1_v[ch];
        if (cfg_addr == 6'(17 + 2*ch)) rdata_d = c2_v[ch];
        if (cfg_addr == 6'(32 + ch))   rdata_d = CNT_W'(fn_v[ch]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      up_q    <= 1'b0;
      presc_q <= '0;
      pen_q   <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      pwm_q   <= '0;
      rdata_q <= '0;
      per_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c1_q[ch] <= '0;
        c2_q[ch] <= '0;
        fn_q[ch] <= '0;
      end
    end else begin
      if (we_ctrl) begin
        en_q <= cfg_wdata[0];
        up_q <= cfg_wdata[1];
      end
      if (cfg_we && cfg_addr == 6'h02) presc_q <= cfg_wdata[PRESC_W-1:0];
      if (cfg_we && cfg_addr == 6'h03) pen_q <= cfg_wdata[NUM_CH-1:0];
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      rdata_q <= rdata_d;
      if (load) begin
        per_q <= per_w;
        c1_q  <= c1_w;
        c2_q  <= c2_w;
        fn_q  <= fn_w;
      end
    end
  end

  assign cfg_rdata   = rdata_q;
  assign pwm_out     = pwm_q;
  assign period_tick = upd;

endmodule

// File: tb/tb_pwm_multichannel_core.sv
// Bench for pwm_multichannel_core: vector table, random configs vs closed-form model,
// and hand sequences for shadow update, counter_reset and async reset.
module tb_pwm_multichannel_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_re = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic [3:0]  pwm_out;
  logic        period_tick;

  int vectors = 0;
  int miscompares = 0;

  pwm_multichannel_core #(.NUM_CH(4), .CNT_W(16), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               up;
    int               per;
    int               ps;
    logic [3:0]       pen;
    logic [3:0][1:0]  fn;
    logic [3:0][15:0] c1;
    logic [3:0][15:0] c2;
    int               ncyc;
    logic [3:0][7:0]  hi;
    int               nt;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    step();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  // counter value after k prescaler ticks, starting from 0
  function automatic int cnt_after(int k, bit up, int per);
    if (up) return k % (per + 1);
    if (k == 0) return 0;
    return per - ((k - 1) % (per + 1));
  endfunction

  function automatic bit fout(logic [1:0] fn, int c1, int c2, int c);
    case (fn)
      2'd0:    return (c1 != 0) && (c <= c1);
      2'd1:    return c >= c1;
      2'd2:    return (c >= c1) && (c < c2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic setup(input vec_t v);
    wr(6'h00, 16'h0004);
    wr(6'h01, 16'(v.per));
    wr(6'h02, 16'(v.ps));
    wr(6'h03, {12'h0, v.pen});
    for (int ch = 0; ch < 4; ch++) begin
      wr(6'(16 + 2*ch), v.c1[ch]);
      wr(6'(17 + 2*ch), v.c2[ch]);
      wr(6'(32 + ch), {14'h0, v.fn[ch]});
    end
    wr(6'h00, {14'h0, v.up, 1'b1});
  endtask

  task automatic run(input vec_t v, input bit tot);
    int hi[4];
    int nt, cn, cp;
    logic [3:0] ep;
    bit ept;
    setup(v);
    cfg_re = 1'b1; cfg_addr = 6'h04;
    hi = '{default: 0};
    nt = 0;
    for (int n = 0; n <= v.ncyc; n++) begin
      cn = cnt_after(n / (v.ps + 1), v.up, v.per);
      cp = (n == 0) ? 0 : cnt_after((n - 1) / (v.ps + 1), v.up, v.per);
      ept = ((n % (v.ps + 1)) == v.ps) && (v.up ? (cn == v.per) : (cn == 0));
      for (int ch = 0; ch < 4; ch++)
        ep[ch] = fout(v.fn[ch], int'(v.c1[ch]), int'(v.c2[ch]), cp) & v.pen[ch];
      chk("pwm_out", pwm_out, ep);
      chk("period_tick", period_tick, ept);
      if (n >= 1) chk("counter", cfg_rdata, cp);
      if (n >= 1) for (int ch = 0; ch < 4; ch++) hi[ch] += int'(pwm_out[ch]);
      if (n < v.ncyc) nt += int'(period_tick);
      step();
    end
    cfg_re = 1'b0;
    if (tot) begin
      for (int ch = 0; ch < 4; ch++)
        chk($sformatf("duty_ch%0d", ch), hi[ch], v.hi[ch]);
      chk("tick_count", nt, v.nt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    vec_t r;

    tbl[0] = '{up:1, per:7, ps:0, pen:4'hF,
               fn:{2'd2, 2'd1, 2'd2, 2'd0},
               c1:{16'd5, 16'd5, 16'd2, 16'd3},
               c2:{16'd5, 16'd0, 16'd6, 16'd0},
               ncyc:16, hi:{8'd0, 8'd6, 8'd8, 8'd8}, nt:2};
    tbl[1] = '{up:1, per:7, ps:0, pen:4'hF,
               fn:{2'd1, 2'd0, 2'd3, 2'd0},
               c1:{16'd0, 16'd7, 16'd4, 16'd0},
               c2:{16'd0, 16'd0, 16'd0, 16'd0},
               ncyc:24, hi:{8'd24, 8'd24, 8'd0, 8'd0}, nt:3};
    tbl[2] = '{up:0, per:4, ps:3, pen:4'hF,
               fn:{2'd3, 2'd2, 2'd1, 2'd0},
               c1:{16'd0, 16'd1, 16'd4, 16'd2},
               c2:{16'd0, 16'd3, 16'd0, 16'd0},
               ncyc:20, hi:{8'd0, 8'd8, 8'd4, 8'd12}, nt:1};
    tbl[3] = tbl[0];
    tbl[3].pen = 4'b0101;
    tbl[3].hi  = {8'd0, 8'd6, 8'd0, 8'd8};
    tbl[4] = '{up:1, per:0, ps:1, pen:4'hF,
               fn:{2'd1, 2'd2, 2'd1, 2'd0},
               c1:{16'd1, 16'd0, 16'd0, 16'd1},
               c2:{16'd0, 16'd1, 16'd0, 16'd0},
               ncyc:10, hi:{8'd0, 8'd10, 8'd10, 8'd10}, nt:5};

    #1;
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_period_tick", period_tick, 0);
    chk("rst_rdata", cfg_rdata, 0);
    step();
    rst_n = 1'b1;
    step();
    rd(6'h04, d); chk("rst_counter", d, 0);
    rd(6'h00, d); chk("rst_ctrl", d, 0);
    wr(6'h3F, 16'hFFFF);
    rd(6'h3F, d); chk("unmapped_read", d, 0);

    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 6'h01; cfg_wdata = 16'd9;
    step();
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("we_re_prewrite", cfg_rdata, 0);
    rd(6'h01, d); chk("period_readback", d, 9);

    for (int i = 0; i < 5; i++) run(tbl[i], 1'b1);

    for (int i = 0; i < 25; i++) begin
      r.up   = 1'($urandom_range(0, 1));
      r.per  = int'($urandom_range(0, 12));
      r.ps   = int'($urandom_range(0, 2));
      r.pen  = 4'($urandom_range(0, 15));
      for (int ch = 0; ch < 4; ch++) begin
        r.fn[ch] = 2'($urandom_range(0, 3));
        r.c1[ch] = 16'($urandom_range(0, r.per + 1));
        r.c2[ch] = 16'($urandom_range(0, r.per + 1));
      end
      r.ncyc = 30;
      r.hi   = '0;
      r.nt   = 0;
      run(r, 1'b0);
    end

    // compare update mid-period
    setup(tbl[0]);
    repeat (4) step();
    wr(6'h10, 16'd6);
    step();
`ifdef PWM_SHADOW_UPDATE_EN
    chk("c1_mid_period", pwm_out[0], 0);
`else
    chk("c1_mid_period", pwm_out[0], 1);
`endif
    repeat (8) step();
    chk("c1_next_period", pwm_out[0], 1);
    wr(6'h03, 16'h0000);
    chk("pwm_en_lag", pwm_out[0], 1);
    step();
    chk("pwm_en_off", pwm_out, 0);

    // counter_reset on the wrapping tick suppresses period_tick
    setup(tbl[0]);
    repeat (7) step();
    cfg_we = 1'b1; cfg_addr = 6'h00; cfg_wdata = 16'h0007;
    #1;
    chk("clr_no_tick", period_tick, 0);
    step();
    cfg_we = 1'b0;
    rd(6'h04, d); chk("clr_counter0", d, 0);
    rd(6'h04, d); chk("clr_counter1", d, 1);
    rd(6'h00, d); chk("clr_selfclear", d, 3);
    repeat (4) step();
    chk("tick_after_clr", period_tick, 1);

    // asynchronous reset mid-period
    repeat (2) step();
    chk("pre_rst_pwm", pwm_out[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pwm_out", pwm_out, 0);
    chk("async_tick", period_tick, 0);
    chk("async_rdata", cfg_rdata, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rd(6'h04, d); chk("post_rst_counter", d, 0);
    rd(6'h00, d); chk("post_rst_ctrl", d, 0);
    rd(6'h01, d); chk("post_rst_period", d, 0);
    rd(6'h10, d); chk("post_rst_c1", d, 0);
    chk("post_rst_pwm", pwm_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
